// File: rtl/hazard_controller_if.sv
// Decode-in / control-out bundle between the ID stage and the hazard controller.
//   ID decode inputs : idRs, idRt, idRd, idRegWrite, idRegDst, idMemRead,
//                      idUsesRt, idBranch, idJump, equal
//   Control outputs  : pcSrc, aSel, bSel, pcWrite, ifidWrite, ifFlush, stall,
//                      controlSel, stallCount, flushCount
// master = decode side (drives ID fields), slave = hazard controller.
interface hazard_controller_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] idRs;
  logic [REG_AW-1:0] idRt;
  logic [REG_AW-1:0] idRd;
  logic              idRegWrite;
  logic              idRegDst;
  logic              idMemRead;
  logic              idUsesRt;
  logic              idBranch;
  logic              idJump;
  logic              equal;

  logic [1:0]        pcSrc;
  logic [1:0]        aSel;
  logic [1:0]        bSel;
  logic              pcWrite;
  logic              ifidWrite;
  logic              ifFlush;
  logic              stall;
  logic              controlSel;
  logic [CNT_W-1:0]  stallCount;
  logic [CNT_W-1:0]  flushCount;

  modport master (
    output idRs, idRt, idRd, idRegWrite, idRegDst, idMemRead, idUsesRt,
           idBranch, idJump, equal,
    input  pcSrc, aSel, bSel, pcWrite, ifidWrite, ifFlush, stall, controlSel,
           stallCount, flushCount
  );

  modport slave (
    input  idRs, idRt, idRd, idRegWrite, idRegDst, idMemRead, idUsesRt,
           idBranch, idJump, equal,
    output pcSrc, aSel, bSel, pcWrite, ifidWrite, ifFlush, stall, controlSel,
           stallCount, flushCount
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencer for a 5-stage MIPS datapath. Tracks a shadow copy of the
// EX/MEM/WB register usage, stalls on load-use and branch-operand hazards,
// selects ALU operand forwarding, and redirects/flushes on jumps and taken
// branches. Also keeps saturating stall and flush counters.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   hz   - hazard_controller_if.slave (ID decode in, pipeline control out)
module hazard_controller #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_controller_if.slave  hz
);

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dst;
    logic              reg_write;
    logic              mem_read;
  } ex_stage_t;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic              reg_write;
  } wr_stage_t;

  ex_stage_t ex_q;
  wr_stage_t mem_q;
  wr_stage_t wb_q;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic [REG_AW-1:0] id_dst;
  logic              load_use;
  logic              branch_hazard;
  logic              stall_c;

  logic [1:0] pc_src;
  logic       pc_write;
  logic       ifid_write;
  logic       if_flush;
  logic       control_sel;
  logic       stall_out;
  logic [1:0] a_sel;
  logic [1:0] b_sel;

  // A producer feeds a consumer only if it really writes, the addresses agree,
  // and the address is not r0 (hard-wired zero never creates a dependency).
  function automatic logic dep(input logic wr, input logic [REG_AW-1:0] dst,
                               input logic [REG_AW-1:0] src);
    return wr && (dst == src) && (dst != '0);
  endfunction

  assign id_dst = hz.idRegDst ? hz.idRd : hz.idRt;

  assign load_use = ex_q.mem_read &&
                    (dep(ex_q.reg_write, ex_q.dst, hz.idRs) ||
                     (hz.idUsesRt && dep(ex_q.reg_write, ex_q.dst, hz.idRt)));

  // The branch compares in ID, so a producer still in EX or MEM must drain
  // first. EX costs two bubbles and MEM one, simply by re-evaluating each
  // cycle as the producer moves down. WB is covered by the write-through
  // register file.
  assign branch_hazard = hz.idBranch &&
                         (dep(ex_q.reg_write,  ex_q.dst,  hz.idRs) ||
                          dep(ex_q.reg_write,  ex_q.dst,  hz.idRt) ||
                          dep(mem_q.reg_write, mem_q.dst, hz.idRs) ||
                          dep(mem_q.reg_write, mem_q.dst, hz.idRt));

  assign stall_c = load_use || branch_hazard;

  // NOTE: every output gets a default before any branch, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pc_src      = 2'd0;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    if_flush    = 1'b0;
    control_sel = 1'b0;
    stall_out   = 1'b0;
    // Outputs are held quiet while reset is asserted, even mid-cycle.
    if (rst) begin
      if (stall_c) begin
        // Stall wins over any redirect; the branch/jump is retried once the
        // hazard clears.
        stall_out = 1'b1;
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        control_sel = 1'b1;
        if (hz.idJump) begin
          pc_src   = 2'd2;
          if_flush = 1'b1;
        end else if (hz.idBranch && hz.equal) begin
          pc_src   = 2'd1;
          if_flush = 1'b1;
        end
      end
    end
  end

  // Forwarding looks only at the shadow pipeline; MEM holds the younger
  // result, so it takes priority over WB.
  assign a_sel = dep(mem_q.reg_write, mem_q.dst, ex_q.rs) ? 2'd1 :
                 dep(wb_q.reg_write,  wb_q.dst,  ex_q.rs) ? 2'd2 : 2'd0;
  assign b_sel = dep(mem_q.reg_write, mem_q.dst, ex_q.rt) ? 2'd1 :
                 dep(wb_q.reg_write,  wb_q.dst,  ex_q.rt) ? 2'd2 : 2'd0;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; MEM<=EX and WB<=MEM must see the old EX/MEM contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the shadow pipeline is a handful of flops, not a memory, so it
      // is reset along with the counters; a bubble is simply all-zero.
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_c) begin
        ex_q <= '0;
      end else begin
        ex_q.rs        <= hz.idRs;
        ex_q.rt        <= hz.idRt;
        ex_q.dst       <= id_dst;
        ex_q.reg_write <= hz.idRegWrite;
        ex_q.mem_read  <= hz.idMemRead;
      end
      mem_q.dst       <= ex_q.dst;
      mem_q.reg_write <= ex_q.reg_write;
      wb_q            <= mem_q;

      if (stall_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.pcSrc      = pc_src;
  assign hz.aSel       = a_sel;
  assign hz.bSel       = b_sel;
  assign hz.pcWrite    = pc_write;
  assign hz.ifidWrite  = ifid_write;
  assign hz.ifFlush    = if_flush;
  assign hz.stall      = stall_out;
  assign hz.controlSel = control_sel;
  assign hz.stallCount = stall_cnt;
  assign hz.flushCount = flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus random
// instruction streams compared against an instruction-level pipeline model.
// Counters are instantiated 8 bits wide so saturation is reachable quickly.
module tb_hazard_controller;

  localparam int REG_AW  = 5;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  hazard_controller_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_controller #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One decoded instruction as seen in ID.
  typedef struct {
    logic [4:0] rs, rt, rd;
    bit wr, dst_rd, ld, uses_rt, br, jmp, eq;
  } instr_t;

  // One in-flight instruction in the model pipeline: [0]=EX, [1]=MEM, [2]=WB.
  typedef struct {
    logic [4:0] rs, rt, dst;
    bit wr, ld;
  } slot_t;

  slot_t pipe [3];
  int    stalls_seen;
  int    flushes_seen;

  int n_vec;
  int n_err;

  // Last observed DUT outputs, for directed scenario checks.
  logic [1:0] obs_pc, obs_a, obs_b;
  logic       obs_pcw, obs_ctrl, obs_flush, obs_stall;
  logic [CNT_W-1:0] obs_scnt, obs_fcnt;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- instruction constructors ----------------
  function automatic instr_t nop();
    instr_t i;
    i = '{rs: 5'd0, rt: 5'd0, rd: 5'd0, wr: 0, dst_rd: 0, ld: 0, uses_rt: 0,
          br: 0, jmp: 0, eq: 0};
    return i;
  endfunction

  function automatic instr_t alu(input int d, input int s, input int t);
    instr_t i = nop();
    i.rd = 5'(d); i.rs = 5'(s); i.rt = 5'(t);
    i.wr = 1; i.dst_rd = 1; i.uses_rt = 1;
    return i;
  endfunction

  function automatic instr_t lw(input int t, input int base);
    instr_t i = nop();
    i.rt = 5'(t); i.rs = 5'(base);
    i.wr = 1; i.ld = 1;
    return i;
  endfunction

  function automatic instr_t beq(input int s, input int t, input bit e);
    instr_t i = nop();
    i.rs = 5'(s); i.rt = 5'(t); i.uses_rt = 1; i.br = 1; i.eq = e;
    return i;
  endfunction

  function automatic instr_t jmp();
    instr_t i = nop();
    i.jmp = 1;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int r1 = int'($urandom_range(0, 7));
    int r2 = int'($urandom_range(0, 7));
    int r3 = int'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0: i = nop();
      1: i = alu(r1, r2, r3);
      2: i = lw(r1, r2);
      3: i = beq(r1, r2, 1'($urandom_range(0, 1)));
      4: i = jmp();
      default: begin
        i.rs = 5'(r1); i.rt = 5'(r2); i.rd = 5'(r3);
        i.wr = 1'($urandom); i.dst_rd = 1'($urandom); i.ld = 1'($urandom);
        i.uses_rt = 1'($urandom); i.br = 1'($urandom); i.jmp = 1'($urandom);
        i.eq = 1'($urandom);
      end
    endcase
    return i;
  endfunction

  // ---------------- reference model ----------------
  function automatic bit produces(input slot_t s, input logic [4:0] r);
    return s.wr && (s.dst == r) && (r != 5'd0);
  endfunction

  // Youngest in-flight producer (MEM before WB) of a register read in EX.
  function automatic int fwd_from(input logic [4:0] r);
    for (int k = 1; k < 3; k++)
      if (produces(pipe[k], r)) return k;
    return 0;
  endfunction

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  function automatic slot_t bubble();
    slot_t s = '{rs: 5'd0, rt: 5'd0, dst: 5'd0, wr: 0, ld: 0};
    return s;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = bubble();
    stalls_seen  = 0;
    flushes_seen = 0;
  endtask

  task automatic drive(input instr_t i);
    bus.idRs       = i.rs;
    bus.idRt       = i.rt;
    bus.idRd       = i.rd;
    bus.idRegWrite = i.wr;
    bus.idRegDst   = i.dst_rd;
    bus.idMemRead  = i.ld;
    bus.idUsesRt   = i.uses_rt;
    bus.idBranch   = i.br;
    bus.idJump     = i.jmp;
    bus.equal      = i.eq;
  endtask

  task automatic capture();
    obs_pc    = bus.pcSrc;     obs_a     = bus.aSel;   obs_b  = bus.bSel;
    obs_pcw   = bus.pcWrite;   obs_ctrl  = bus.controlSel;
    obs_flush = bus.ifFlush;   obs_stall = bus.stall;
    obs_scnt  = bus.stallCount; obs_fcnt = bus.flushCount;
  endtask

  // Starts and ends at a falling edge: apply one ID instruction, compare every
  // output against the model, then let one rising edge advance both.
  task automatic step(input instr_t i);
    bit   hazard, redirect;
    int   e_pc;
    slot_t incoming;
    drive(i);
    #1;
    hazard = (pipe[0].ld && (produces(pipe[0], i.rs) ||
                             (i.uses_rt && produces(pipe[0], i.rt)))) ||
             (i.br && (produces(pipe[0], i.rs) || produces(pipe[0], i.rt) ||
                       produces(pipe[1], i.rs) || produces(pipe[1], i.rt)));
    redirect = !hazard && (i.jmp || (i.br && i.eq));
    e_pc = hazard ? 0 : i.jmp ? 2 : (i.br && i.eq) ? 1 : 0;

    check("pcSrc",      32'(bus.pcSrc),      32'(e_pc));
    check("pcWrite",    32'(bus.pcWrite),    32'(!hazard));
    check("ifidWrite",  32'(bus.ifidWrite),  32'(!hazard));
    check("controlSel", 32'(bus.controlSel), 32'(!hazard));
    check("stall",      32'(bus.stall),      32'(hazard));
    check("ifFlush",    32'(bus.ifFlush),    32'(redirect));
    check("aSel",       32'(bus.aSel),       32'(fwd_from(pipe[0].rs)));
    check("bSel",       32'(bus.bSel),       32'(fwd_from(pipe[0].rt)));
    check("stallCount", 32'(bus.stallCount), 32'(sat(stalls_seen)));
    check("flushCount", 32'(bus.flushCount), 32'(sat(flushes_seen)));
    capture();

    @(posedge clk);
    if (hazard) begin
      incoming = bubble();
      stalls_seen++;
    end else begin
      incoming.rs  = i.rs;
      incoming.rt  = i.rt;
      incoming.dst = i.dst_rd ? i.rd : i.rt;
      incoming.wr  = i.wr;
      incoming.ld  = i.ld;
    end
    if (redirect) flushes_seen++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = incoming;
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_pcSrc"},      32'(bus.pcSrc),      0);
    check({tag, "_aSel"},       32'(bus.aSel),       0);
    check({tag, "_bSel"},       32'(bus.bSel),       0);
    check({tag, "_pcWrite"},    32'(bus.pcWrite),    0);
    check({tag, "_ifidWrite"},  32'(bus.ifidWrite),  0);
    check({tag, "_ifFlush"},    32'(bus.ifFlush),    0);
    check({tag, "_stall"},      32'(bus.stall),      0);
    check({tag, "_controlSel"}, 32'(bus.controlSel), 0);
    check({tag, "_stallCount"}, 32'(bus.stallCount), 0);
    check({tag, "_flushCount"}, 32'(bus.flushCount), 0);
  endtask

  // Starts and ends at a falling edge; leaves reset released with a nop in ID.
  task automatic do_reset();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive(rand_instr());
      #1;
      check_quiet("rst");
      @(negedge clk);
    end
    model_clear();
    drive(nop());
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    drive(nop());
    model_clear();
    @(negedge clk);

    // Reset and release with idle nops.
    do_reset();
    step(nop());
    check("idle_pcWrite", 32'(obs_pcw),  1);
    check("idle_ctrl",    32'(obs_ctrl), 1);
    check("idle_pcSrc",   32'(obs_pc),   0);
    step(nop());

    // Load-use: lw r5 then add r6,r5,r7.
    do_reset();
    step(lw(5, 1));
    step(alu(6, 5, 7));
    check("lu_stall",   32'(obs_stall), 1);
    check("lu_pcWrite", 32'(obs_pcw),   0);
    check("lu_ctrl",    32'(obs_ctrl),  0);
    step(alu(6, 5, 7));
    check("lu_resume",  32'(obs_stall), 0);
    step(nop());
    check("lu_aSel",    32'(obs_a),     2);
    check("lu_count",   32'(obs_scnt),  1);

    // Forwarding distance 1, distance 2 and r0 destination.
    do_reset();
    step(alu(3, 1, 2)); step(alu(4, 3, 3)); step(nop());
    check("fwd1_aSel", 32'(obs_a), 1);
    check("fwd1_bSel", 32'(obs_b), 1);
    do_reset();
    step(alu(3, 1, 2)); step(alu(10, 11, 12)); step(alu(4, 3, 3)); step(nop());
    check("fwd2_aSel", 32'(obs_a), 2);
    check("fwd2_bSel", 32'(obs_b), 2);
    do_reset();
    step(alu(0, 1, 2)); step(alu(4, 0, 0)); step(nop());
    check("fwd0_aSel", 32'(obs_a), 0);
    check("fwd0_bSel", 32'(obs_b), 0);

    // Branch operand hazard with 0, 1 and 2 instructions between.
    do_reset();
    step(alu(8, 1, 2));
    repeat (3) step(beq(8, 9, 1'b0));
    step(nop());
    check("br_gap0_stalls", 32'(obs_scnt), 2);
    do_reset();
    step(alu(8, 1, 2)); step(nop());
    repeat (2) step(beq(8, 9, 1'b0));
    step(nop());
    check("br_gap1_stalls", 32'(obs_scnt), 1);
    do_reset();
    step(alu(8, 1, 2)); step(nop()); step(nop());
    step(beq(8, 9, 1'b0));
    step(nop());
    check("br_gap2_stalls", 32'(obs_scnt), 0);

    // Taken, not-taken, jump.
    do_reset();
    step(beq(1, 2, 1'b1));
    check("taken_pcSrc", 32'(obs_pc),    1);
    check("taken_flush", 32'(obs_flush), 1);
    step(nop());
    check("taken_once",  32'(obs_flush), 0);
    check("taken_count", 32'(obs_fcnt),  1);
    step(beq(1, 2, 1'b0));
    check("ntaken_pcSrc", 32'(obs_pc),    0);
    check("ntaken_flush", 32'(obs_flush), 0);
    step(jmp());
    check("jump_pcSrc", 32'(obs_pc),    2);
    check("jump_flush", 32'(obs_flush), 1);

    // Taken branch with pending hazard: stall wins until it clears.
    do_reset();
    step(alu(8, 1, 2));
    step(beq(8, 9, 1'b1));
    check("prio_flush0", 32'(obs_flush), 0);
    check("prio_stall0", 32'(obs_stall), 1);
    step(beq(8, 9, 1'b1));
    check("prio_flush1", 32'(obs_flush), 0);
    step(beq(8, 9, 1'b1));
    check("prio_flush2", 32'(obs_flush), 1);
    check("prio_pcSrc2", 32'(obs_pc),    1);

    // Counter saturation: 260 stalls (> 2^CNT_W + 3) and 260+ flushes.
    do_reset();
    for (int n = 0; n < 130; n++) begin
      step(alu(8, 1, 2));
      repeat (3) step(beq(8, 9, 1'b1));
    end
    step(nop());
    check("sat_stallCount", 32'(obs_scnt), CNT_MAX);
    repeat (260) step(jmp());
    step(nop());
    check("sat_flushCount", 32'(obs_fcnt), CNT_MAX);

    // Reset asserted in the middle of a stall cycle.
    step(alu(8, 1, 2));
    drive(beq(8, 9, 1'b1));
    #1;
    check("midrst_pre_stall", 32'(bus.stall), 1);
    rst = 1'b0;
    #1;
    check_quiet("midrst");
    @(negedge clk);
    model_clear();
    drive(nop());
    rst = 1'b1;

    // Random instruction streams.
    for (int n = 0; n < 1500; n++) step(rand_instr());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencer for the 5-stage MIPS datapath: drives pcSrc, pcWrite, ifidWrite, ifFlush, stall, controlSel, aSel and bSel.
- Keeps its own shadow pipeline (EX/MEM/WB) of destination and source register info. Needs only ID-stage decode inputs.
- Resolves load-use and branch-operand hazards by stalling, ALU-operand hazards by forwarding, and taken branches and jumps by flushing IF/ID.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
idRs  in  REG_AW  Rs field of instruction in ID
idRt  in  REG_AW  Rt field of instruction in ID
idRd  in  REG_AW  Rd field of instruction in ID
idRegWrite  in  1  ID instruction writes a register
idRegDst  in  1  1: destination is Rd, 0: destination is Rt
idMemRead  in  1  ID instruction is a load
idUsesRt  in  1  ID instruction reads Rt as a source
idBranch  in  1  ID instruction is beq
idJump  in  1  ID instruction is j
equal  in  1  ID comparator result (regData1 == regData2)
pcSrc  out  2  0: PC+4, 1: branch target, 2: jump target
aSel  out  2  ALU A source: 0 regfile, 1 MEM forward, 2 WB forward
bSel  out  2  ALU B pre-mux source, same encoding as aSel
pcWrite  out  1  PC load enable
ifidWrite  out  1  IF/ID load enable
ifFlush  out  1  zero IF/ID on next edge
stall  out  1  bubble inserted this cycle
controlSel  out  1  0: ID control signals forced to zero
stallCount  out  CNT_W  stall cycles since reset, saturating
flushCount  out  CNT_W  flushes since reset, saturating

Behaviour:
- Shadow registers:
  - exRs, exRt, exDst, exRegWrite, exMemRead
  - memDst, memRegWrite
  - wbDst, wbRegWrite
- Reset (rst=0, immediate, mid-operation included):
  - All shadow registers and counters go to 0.
  - pcWrite=0, ifidWrite=0, ifFlush=0, stall=0, controlSel=0, pcSrc=0, aSel=0, bSel=0.
- ID destination: idDst = idRegDst ? idRd : idRt.
- A destination matches a source only when the shadow regWrite=1, the addresses are equal, and the destination is nonzero. Register 0 never matches.
- The register file is write-through: an ID read in the same cycle as the WB write returns the new value.
- Hazard conditions (combinational, re-evaluated every cycle):
  - Load-use: exMemRead and exDst matches idRs, or matches idRt with idUsesRt.
  - Branch hazard: idBranch, and exDst or memDst matches idRs or idRt.
  - Result: the EX case needs 2 stall cycles and the MEM case needs 1, through natural re-evaluation. WB needs none.
  - stall = load-use OR branch hazard.
- Stall cycle:
  - pcWrite=0, ifidWrite=0, controlSel=0, pcSrc=0, ifFlush=0.
  - Next edge: shadow EX loads a bubble (all 0); MEM<=EX, WB<=MEM.
  - stallCount++ (saturating).
- Normal cycle:
  - pcWrite=1, ifidWrite=1, controlSel=1.
  - Shadow EX loads {idRs, idRt, idDst, idRegWrite, idMemRead}; MEM<=EX, WB<=MEM.
- Control flow, when not stalled:
  - idJump: pcSrc=2, ifFlush=1.
  - idBranch and equal: pcSrc=1, ifFlush=1.
  - Otherwise: pcSrc=0, ifFlush=0.
  - flushCount++ when ifFlush=1 (saturating).
  - Stall has priority over any flush.
- Forwarding (from shadow registers only, no input dependency):
  - aSel=1 if memDst matches exRs; else 2 if wbDst matches exRs; else 0.
  - bSel uses the same rule against exRt.
  - MEM has priority over WB.
- Counters saturate at all-ones and never wrap.
- No other latency: all outputs except aSel, bSel and the counters are combinational from inputs and state within the cycle.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0. Release with idle nops -> pcWrite=ifidWrite=controlSel=1, pcSrc=0.
- Load-use: lw r5 in ID, then add r6,r5,r7 (idRs=5) -> exactly 1 stall cycle (pcWrite=0, controlSel=0). Add enters EX 1 cycle late with aSel=2. stallCount=1.
- Forwarding: add r3,r1,r2 then sub r4,r3,r3 -> sub in EX has aSel=1, bSel=1. Repeat with one independent instruction between -> aSel=2, bSel=2. Destination r0 -> aSel=bSel=0.
- Branch hazard: add r8 immediately followed by beq r8,r9 -> 2 stall cycles. With one instruction gap -> 1 stall. With two instruction gap -> 0 stalls.
- Taken/not taken/jump: beq with equal=1 -> pcSrc=1, ifFlush=1 for 1 cycle, flushCount=1. equal=0 -> pcSrc=0, no flush. j -> pcSrc=2, ifFlush=1.
- Simultaneous/saturation: beq with equal=1 and a pending branch hazard -> stall wins, ifFlush=0 until the hazard clears. Force 2^CNT_W+3 stalls -> stallCount holds at all-ones. Assert rst mid-stall -> outputs 0 immediately.
